// File: rtl/comparator_iterative.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from the MSB
// and stops at the first differing chunk. Signed mode uses offset binary on the top chunk.
module comparator_iterative #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_valid,
    output logic                                 start_ready,
    input  logic [WIDTH-1:0]                     A,
    input  logic [WIDTH-1:0]                     B,
    input  logic                                 is_signed,
    output logic                                 busy,
    output logic                                 result_valid,
    output logic                                 AltB,
    output logic                                 AeqB,
    output logic                                 AgtB,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]     chunks_used
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $fatal(1, "comparator_iterative: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sgn_r;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    // Flipping the top bit on both sides turns a two's-complement compare into an unsigned one.
    always_comb begin
        ca = a_r[int'(idx) * CHUNK +: CHUNK];
        cb = b_r[int'(idx) * CHUNK +: CHUNK];
        if (sgn_r && (idx == TOP)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            AltB        <= 1'b0;
            AeqB        <= 1'b0;
            AgtB        <= 1'b0;
            chunks_used <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sgn_r       <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r   <= A;
                        b_r   <= B;
                        sgn_r <= is_signed;
                        idx   <= TOP;
                        cnt   <= CW'(1);
                        state <= CMP;
                    end
                end
                CMP: begin
                    if ((ca != cb) || (idx == '0)) begin
                        AltB        <= (ca < cb);
                        AeqB        <= (ca == cb);
                        AgtB        <= (ca > cb);
                        chunks_used <= cnt;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
